// File: rtl/tlc_serial_shifter.sv
// Serial word transmitter for TLC5955-class LED driver chains: MSB-first on
// SCLK/SDO with programmable SCLK half-period and optional LAT pulse.
module tlc_serial_shifter #(
  parameter int DATA_W = 16,
  parameter int DIV    = 1,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] DATA,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              LATCH,
  output logic              READY,
  output logic              SCLK,
  output logic              SDO,
  output logic              LAT,
  output logic              DONE,
  output logic              ERR
);

  localparam int                PH_W    = $clog2(DIV + 1);
  localparam logic [PH_W-1:0]   PH_LOAD = PH_W'(DIV - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [LEN_W-1:0]  bit_cnt;
  logic [PH_W-1:0]   phase;
  logic              lat_req;
  logic              ready_r;
  logic              sclk_r;
  logic              lat_r;
  logic              done_r;
  logic              err_r;

  logic              len_ok;
  logic              last_edge;
  logic              accept;
  logic [LEN_W-1:0]  shift_amt;

  assign len_ok    = (LEN != '0) && (LEN <= MAX_LEN);
  assign shift_amt = MAX_LEN - LEN;

  // The edge that finishes a transfer also accepts a waiting START, so
  // consecutive words run with no idle cycle in between.
  assign last_edge = (phase == '0) &&
                     (((state == S_HIGH) && (bit_cnt == LEN_W'(1)) && !lat_req) ||
                      (state == S_LATCH));
  assign accept    = START && ((state == S_IDLE) || last_edge);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      lat_req <= 1'b0;
      ready_r <= 1'b1;
      sclk_r  <= 1'b0;
      lat_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= last_edge;
      err_r  <= accept && !len_ok;
      if (accept && len_ok) begin
        state   <= S_LOW;
        ready_r <= 1'b0;
        sclk_r  <= 1'b0;
        lat_r   <= 1'b0;
        shreg   <= DATA << shift_amt;
        bit_cnt <= LEN;
        lat_req <= LATCH;
        phase   <= PH_LOAD;
      end else if (state != S_IDLE) begin
        if (phase != '0) begin
          phase <= phase - 1'b1;
        end else begin
          phase <= PH_LOAD;
          case (state)
            S_LOW: begin
              sclk_r <= 1'b1;
              state  <= S_HIGH;
            end
            S_HIGH: begin
              // Zero fill leaves SDO low once the last bit has gone out.
              sclk_r  <= 1'b0;
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == LEN_W'(1)) begin
                if (lat_req) begin
                  state <= S_LATCH;
                  lat_r <= 1'b1;
                end else begin
                  state   <= S_IDLE;
                  ready_r <= 1'b1;
                end
              end else begin
                state <= S_LOW;
              end
            end
            S_LATCH: begin
              lat_r   <= 1'b0;
              state   <= S_IDLE;
              ready_r <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign READY = ready_r;
  assign SCLK  = sclk_r;
  assign SDO   = shreg[DATA_W-1];
  assign LAT   = lat_r;
  assign DONE  = done_r;
  assign ERR   = err_r;

endmodule
